// File: rtl/eda_regional_max_pkg.sv
// Shared types for the eda_regional_max controller: FSM states, default-geometry
// address typedefs and the {row,col} address builder.
package eda_regional_max_pkg;

  localparam int unsigned DEF_M       = 6;
  localparam int unsigned DEF_N       = 6;
  localparam int unsigned DEF_I_WIDTH = $clog2(DEF_M);
  localparam int unsigned DEF_J_WIDTH = $clog2(DEF_N);

  typedef logic [DEF_I_WIDTH-1:0]             row_t;
  typedef logic [DEF_J_WIDTH-1:0]             col_t;
  typedef logic [DEF_I_WIDTH+DEF_J_WIDTH-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_FLUSH,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  // Addresses are a {row,col} concatenation, so col occupies the low col_w bits.
  function automatic int unsigned mk_addr(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned col_w);
    return (row << col_w) | col;
  endfunction

endpackage

// File: rtl/eda_raster_cnt.sv
// Raster-order row/col counter: col wraps COLS-1 -> 0 with row++, row wraps ROWS-1 -> 0.
module eda_raster_cnt #(
  parameter int unsigned ROWS  = 6,
  parameter int unsigned COLS  = 6,
  parameter int unsigned ROW_W = 3,
  parameter int unsigned COL_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic row_last;
  logic col_last;

  assign row_last = (row == ROW_W'(ROWS - 1));
  assign col_last = (col == COL_W'(COLS - 1));
  assign last     = row_last && col_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/eda_regional_max_ctrl.sv
// Frame sequencer for the eda_regional_max core: clear, raster load, scan, drain, done.
// Optional EDA_CTRL_PERF_EN adds frame_cycles (start sample to frame_done, saturating).
module eda_regional_max_ctrl
  import eda_regional_max_pkg::*;
#(
  parameter  int unsigned M            = 6,
  parameter  int unsigned N            = 6,
  parameter  int unsigned PIXEL_WIDTH  = 8,
  parameter  int unsigned SCAN_STRIDE  = 2,
  parameter  int unsigned CORE_LATENCY = 3,
  localparam int unsigned I_WIDTH      = $clog2(M),
  localparam int unsigned J_WIDTH      = $clog2(N),
  localparam int unsigned ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  output logic                   write_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic [ADDR_WIDTH-1:0]  center_addr,
  output logic                   new_pixel,
  output logic                   clear,
  output logic                   busy,
  output logic                   frame_done
`ifdef EDA_CTRL_PERF_EN
  ,
  output logic [31:0]            frame_cycles
`endif
);

  localparam int unsigned TICK_MAX = (SCAN_STRIDE > CORE_LATENCY) ? SCAN_STRIDE : CORE_LATENCY;
  localparam int unsigned TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  ctrl_state_e        state_q, state_d;
  logic               abort_clr_q, abort_clr_d;
  logic [TICK_W-1:0]  tick_q;
  logic               beat;
  logic               slot_end;
  logic [I_WIDTH-1:0] ld_row, sc_row;
  logic [J_WIDTH-1:0] ld_col, sc_col;
  logic               ld_last, sc_last;

  assign beat     = s_ready && s_valid;
  assign slot_end = (state_q == ST_SCAN) && (tick_q == TICK_W'(SCAN_STRIDE - 1));

  eda_raster_cnt #(.ROWS(M), .COLS(N), .ROW_W(I_WIDTH), .COL_W(J_WIDTH)) u_load_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clear),
    .en     (beat),
    .row    (ld_row),
    .col    (ld_col),
    .last   (ld_last)
  );

  eda_raster_cnt #(.ROWS(M), .COLS(N), .ROW_W(I_WIDTH), .COL_W(J_WIDTH)) u_scan_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clear),
    .en     (slot_end),
    .row    (sc_row),
    .col    (sc_col),
    .last   (sc_last)
  );

  assign center_addr = ADDR_WIDTH'(mk_addr(32'(sc_row), 32'(sc_col), J_WIDTH));

  // CLEAR serves both frame start and abort; abort_clr_q picks its successor.
  always_comb begin
    state_d     = state_q;
    abort_clr_d = abort_clr_q;
    s_ready     = 1'b0;
    clear       = 1'b0;
    new_pixel   = 1'b0;
    frame_done  = 1'b0;
    busy        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_CLEAR;
          abort_clr_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        clear   = 1'b1;
        state_d = abort_clr_q ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && ld_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_SCAN;
      ST_SCAN: begin
        new_pixel = (tick_q == '0);
        if (slot_end && sc_last) state_d = (CORE_LATENCY == 0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tick_q == TICK_W'(CORE_LATENCY - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_CLEAR;
      abort_clr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      abort_clr_q <= 1'b0;
      tick_q      <= '0;
      write_en    <= 1'b0;
      wr_addr     <= '0;
      pixel_in    <= '0;
    end else begin
      state_q     <= state_d;
      abort_clr_q <= abort_clr_d;
      write_en    <= beat && !abort;
      if (beat) begin
        wr_addr  <= ADDR_WIDTH'(mk_addr(32'(ld_row), 32'(ld_col), J_WIDTH));
        pixel_in <= s_data;
      end
      if (state_q == ST_SCAN)       tick_q <= slot_end ? '0 : tick_q + TICK_W'(1);
      else if (state_q == ST_DRAIN) tick_q <= tick_q + TICK_W'(1);
      else                          tick_q <= '0;
    end
  end

`ifdef EDA_CTRL_PERF_EN
  logic [31:0] cyc_q;

  // Re-armed to 1 every idle cycle so the count already reads 1 in the CLEAR cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q        <= '0;
      frame_cycles <= '0;
    end else begin
      if (state_q == ST_IDLE)  cyc_q <= 32'd1;
      else if (cyc_q != '1)    cyc_q <= cyc_q + 32'd1;
      if (frame_done) frame_cycles <= cyc_q;
    end
  end
`endif

endmodule

// File: tb/tb_eda_regional_max_ctrl.sv
// Randomized self-checking bench for eda_regional_max_ctrl against a cycle-schedule model
// derived from accepted beats (write/scan/done times computed arithmetically).
module tb_eda_regional_max_ctrl;

  localparam int unsigned M      = 6;
  localparam int unsigned N      = 6;
  localparam int unsigned MN     = M * N;
  localparam int unsigned PW     = 8;
  localparam int unsigned STRIDE = 2;
  localparam int unsigned LAT    = 3;
  localparam int unsigned JW     = 3;
  localparam int unsigned AW     = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort, s_valid, s_ready;
  logic [PW-1:0] s_data;
  logic          write_en, new_pixel, clear, busy, frame_done;
  logic [AW-1:0] wr_addr, center_addr;
  logic [PW-1:0] pixel_in;
`ifdef EDA_CTRL_PERF_EN
  logic [31:0]   frame_cycles;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  eda_regional_max_ctrl #(
    .M(M), .N(N), .PIXEL_WIDTH(PW), .SCAN_STRIDE(STRIDE), .CORE_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .write_en(write_en), .wr_addr(wr_addr), .pixel_in(pixel_in),
    .center_addr(center_addr), .new_pixel(new_pixel), .clear(clear),
    .busy(busy), .frame_done(frame_done)
`ifdef EDA_CTRL_PERF_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({clear, s_ready, write_en, new_pixel, frame_done, busy, wr_addr, pixel_in, center_addr});
  endfunction

  function automatic logic [31:0] strobes();
    return 32'({clear, s_ready, write_en, new_pixel, frame_done, busy});
  endfunction

  // Address of the k-th raster position: row k/N, col k%N, as {row,col}.
  function automatic logic [31:0] raster_addr(input int unsigned k);
    return 32'(((k / N) << JW) + (k % N));
  endfunction

  // vmode: 0 = s_valid always 1, 1 = s_valid on odd cycles, 2 = random (~75%).
  // Cycle c is the interval after clock edge c-1; start is sampled at edge 0.
  task automatic run_frame(input int unsigned vmode, input bit do_abort, input bit poke_start,
                           output int unsigned obs_done);
    int unsigned acc, last_acc, abort_cyc, done_at, prev_idx;
    bit prev_acc, finished;
    logic [PW-1:0] pix [MN];
    acc = 0; last_acc = 0; abort_cyc = 0; done_at = 0; prev_idx = 0;
    prev_acc = 1'b0; finished = 1'b0; obs_done = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    for (int unsigned c = 1; c < 600; c++) begin
      bit v, aborted, e_clear, e_ready, e_wr, e_np, e_done, e_busy;
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? c[0] : ($urandom_range(0, 3) != 0);
      s_valid = v;
      s_data  = PW'($urandom);
      start   = poke_start && (c == 5);
      abort   = do_abort && (last_acc != 0) && (c == last_acc + 2 + 9 * STRIDE + 1);
      if (abort) abort_cyc = c;
      @(negedge clk);
      aborted = (abort_cyc != 0) && (c > abort_cyc);
      done_at = (last_acc != 0) ? last_acc + 2 + MN * STRIDE + LAT : 0;
      e_clear = aborted ? (c == abort_cyc + 1) : (c == 1);
      e_ready = !aborted && (c >= 2) && (acc < MN);
      e_wr    = !aborted && prev_acc;
      e_np    = !aborted && (last_acc != 0) && (c >= last_acc + 2) &&
                ((c - last_acc - 2) % STRIDE == 0) && ((c - last_acc - 2) / STRIDE < MN);
      e_done  = !aborted && (last_acc != 0) && (c == done_at);
      e_busy  = aborted ? (c == abort_cyc + 1) : ((last_acc == 0) || (c <= done_at));
      check("strobes", strobes(), 32'({e_clear, e_ready, e_wr, e_np, e_done, e_busy}));
      if (e_wr) begin
        check("wr_addr", 32'(wr_addr), raster_addr(prev_idx));
        check("pixel_in", 32'(pixel_in), 32'(pix[prev_idx]));
      end
      if (e_np) check("center_addr", 32'(center_addr), raster_addr((c - last_acc - 2) / STRIDE));
      if (frame_done) obs_done = c;
      prev_acc = e_ready && v && !abort;
      if (e_ready && v) begin
        pix[acc] = s_data;
        prev_idx = acc;
        acc++;
        if (acc == MN) last_acc = c;
      end
      if ((aborted && c > abort_cyc + 4) || (done_at != 0 && c > done_at + 2)) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!finished) check("frame_timeout", 32'(0), 32'(1));
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    int unsigned done_c;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", strobes(), 32'(0));
    end

    // Reset asserted mid-LOAD drops everything immediately.
    @(posedge clk); #1;
    start = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midframe_reset", all_outputs(), 32'(0));
    s_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_frame(0, 1'b0, 1'b0, done_c);
    check("default_done_cycle", 32'(done_c), 32'(114));
`ifdef EDA_CTRL_PERF_EN
    check("perf_default", frame_cycles, 32'(114));
`endif

    // start and abort together in IDLE: abort wins, nothing starts.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("start_abort_idle", strobes(), 32'(0));
    end

    run_frame(0, 1'b1, 1'b0, done_c);
    check("abort_no_done", 32'(done_c), 32'(0));
`ifdef EDA_CTRL_PERF_EN
    check("perf_after_abort", frame_cycles, 32'(114));
`endif

    run_frame(1, 1'b0, 1'b1, done_c);
    check("toggle_done_cycle", 32'(done_c), 32'(150));

    for (int i = 0; i < 3; i++) begin
      run_frame(2, (i == 1), (i == 2), done_c);
`ifdef EDA_CTRL_PERF_EN
      if (i != 1) check("perf_random", frame_cycles, 32'(done_c));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
